// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - frame handshake interface for uart_frame_tx
//
// Purpose: carries one NCHAR-character result frame from the output queue
//          to the UART serializer. It also carries the serializer's status
//          back to the queue.
// Signals:
//   load  - frame-valid strobe, sampled on clk
//   frame - 8*NCHAR bit character frame, char 0 in the top byte
//   busy  - serializer owns a frame
//   done  - one-cycle pulse when a frame has been fully sent
// Modports: master = frame source, slave = serializer.
interface uart_frame_tx_if #(
  parameter int NCHAR = 14
) ();
  localparam int FRAME_W = 8 * NCHAR;

  logic               load;
  logic [FRAME_W-1:0] frame;
  logic               busy;
  logic               done;

  modport master (output load, output frame, input busy, input done);
  modport slave  (input load, input frame, output busy, output done);
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - NUL-skipping 8N1 UART frame serializer
//
// Purpose: captures one frame of NCHAR ASCII characters and sends each
//          non-NUL character as 8N1 on tx, one bit per baud_tick.
//          NUL bytes are padding and cost no line time.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   baud_tick - one-cycle enable per UART bit period
//   tx        - serial line, idle high
//   bus       - slave side of uart_frame_tx_if (load/frame in, busy/done out)
module uart_frame_tx #(
  parameter int NCHAR = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_tick,
  output logic            tx,
  uart_frame_tx_if.slave  bus
);
  localparam int FRAME_W = 8 * NCHAR;
  localparam int IDX_W   = (NCHAR > 1) ? $clog2(NCHAR) : 1;

  // ARM and NEXT are both "pick a character" points: ARM searches from
  // char 0, NEXT searches after the character whose stop bit just went out.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    DATA,
    STOP,
    NEXT
  } state_t;

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         bit_cnt;

  logic [7:0]         chars [NCHAR];
  logic [7:0]         cur_char;
  logic               nxt_found;
  logic [IDX_W-1:0]   nxt_idx;

  for (genvar g = 0; g < NCHAR; g++) begin : g_chars
    assign chars[g] = frame_q[FRAME_W-1-8*g -: 8];
  end

  assign cur_char = chars[idx_q];

  // Lowest non-NUL index at or after the search start. Scanning from the
  // top down lets the last hit win, so the result is the lowest index.
  // After the last character nothing qualifies, and the frame finishes.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NCHAR - 1; i >= 0; i--) begin
      if (chars[i] != 8'h00 && (state_q == ARM || IDX_W'(i) > idx_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      idx_q    <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        IDLE: begin
          tx <= 1'b1;
          // A tick in the load cycle is deliberately ignored.
          // The start bit waits for the next tick.
          if (bus.load) begin
            frame_q  <= bus.frame;
            idx_q    <= '0;
            bit_cnt  <= '0;
            bus.busy <= 1'b1;
            state_q  <= ARM;
          end
        end
        ARM, NEXT: begin
          if (baud_tick) begin
            if (nxt_found) begin
              // Start bit goes out on this same tick, back-to-back after a stop.
              tx      <= 1'b0;
              idx_q   <= nxt_idx;
              bit_cnt <= '0;
              state_q <= DATA;
            end else begin
              tx       <= 1'b1;
              idx_q    <= '0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            tx <= cur_char[bit_cnt];
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state_q <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            tx      <= 1'b1;
            state_q <= NEXT;
          end
        end
        default: begin
          tx      <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - self-checking bench for uart_frame_tx
module tb_uart_frame_tx;
  localparam int NCHAR = 14;
  localparam int FW    = 8 * NCHAR;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic baud_tick = 1'b0;
  logic tx;

  uart_frame_tx_if #(.NCHAR(NCHAR)) bus ();

  uart_frame_tx #(.NCHAR(NCHAR)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tx        (tx),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected line image: every non-NUL char in order as start, 8 data bits LSB first, stop.
  function automatic int build_exp(input logic [FW-1:0] f);
    logic [7:0] c;
    int m = 0;
    exp_q.delete();
    for (int k = 0; k < NCHAR; k++) begin
      c = f[FW-1-8*k -: 8];
      if (c != 8'h00) begin
        m++;
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(c[b]);
        exp_q.push_back(1'b1);
      end
    end
    return m;
  endfunction

  function automatic logic [FW-1:0] rand_frame(input bit allow_nul);
    logic [FW-1:0] f;
    logic [7:0]    c;
    f = '0;
    for (int k = 0; k < NCHAR; k++) begin
      c = 8'($urandom_range(1, 255));
      if (allow_nul && $urandom_range(0, 2) == 0) c = 8'h00;
      f[FW-1-8*k -: 8] = c;
    end
    return f;
  endfunction

  // One clk cycle: drive at negedge, active posedge, sample at the next negedge.
  task automatic cycle(input logic tk);
    baud_tick = tk;
    @(posedge clk);
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic run_frame(input logic [FW-1:0] f, input bit tick_on_load,
                           input int intrude_at, input string tag);
    int   m;
    int   n;
    int   gap;
    logic prev;
    bus.frame = f;
    bus.load  = 1'b1;
    cycle(tick_on_load);
    bus.load  = 1'b0;
    bus.frame = rand_frame(1'b0);
    chk({tag, ":busy_at_load"}, bus.busy, 1'b1);
    chk({tag, ":tx_at_load"}, tx, 1'b1);
    chk({tag, ":done_at_load"}, bus.done, 1'b0);
    m    = build_exp(f);
    n    = 10 * m + 1;
    prev = 1'b1;
    for (int t = 1; t <= n; t++) begin
      if (t == intrude_at) begin
        bus.load  = 1'b1;
        bus.frame = rand_frame(1'b0);
        cycle(1'b0);
        bus.load  = 1'b0;
        chk($sformatf("%s:busy_after_intrude", tag), bus.busy, 1'b1);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0);
        chk($sformatf("%s:hold_tx_t%0d", tag, t), tx, prev);
        chk($sformatf("%s:hold_done_t%0d", tag, t), bus.done, 1'b0);
      end
      cycle(1'b1);
      if (t < n) begin
        chk($sformatf("%s:tx_t%0d", tag, t), tx, exp_q[t-1]);
        chk($sformatf("%s:busy_t%0d", tag, t), bus.busy, 1'b1);
        chk($sformatf("%s:done_t%0d", tag, t), bus.done, 1'b0);
        prev = exp_q[t-1];
      end else begin
        chk($sformatf("%s:done_end", tag), bus.done, 1'b1);
        chk($sformatf("%s:busy_end", tag), bus.busy, 1'b0);
        chk($sformatf("%s:tx_end", tag), tx, 1'b1);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    cycle(1'b0);
    chk({tag, ":idle_busy"}, bus.busy, 1'b0);
    chk({tag, ":idle_done"}, bus.done, 1'b0);
    chk({tag, ":idle_tx"}, tx, 1'b1);
  endtask

  initial begin
    int m;
    bus.load  = 1'b0;
    bus.frame = '0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:tx", tx, 1'b1);
    chk("reset:busy", bus.busy, 1'b0);
    chk("reset:done", bus.done, 1'b0);
    rst = 1'b1;
    idle_check("post_reset");

    // Reset during data bit 3 of char 0.
    bus.frame = {8'h41, 104'h0};
    bus.load  = 1'b1;
    cycle(1'b0);
    bus.load  = 1'b0;
    m = build_exp({8'h41, 104'h0});
    repeat (5) cycle(1'b1);
    chk("midrst:tx_bit3", tx, exp_q[4]);
    #2 rst = 1'b0;
    #1;
    chk("midrst:tx_async", tx, 1'b1);
    chk("midrst:busy_async", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      chk($sformatf("midrst:quiet_tx_%0d", i), tx, 1'b1);
      chk($sformatf("midrst:quiet_busy_%0d", i), bus.busy, 1'b0);
    end

    run_frame({8'h41, 104'h0}, 1'b0, 0, "single");
    idle_check("single");
    run_frame("-12345678901\r\n", 1'b0, 0, "full");
    idle_check("full");
    run_frame({80'h0, "42\r\n"}, 1'b0, 0, "nulskip");
    idle_check("nulskip");
    run_frame("ABCDEFGHIJKLMN", 1'b0, 15, "busyload");
    idle_check("busyload");
    run_frame('0, 1'b1, 0, "allnul");
    run_frame({8'h37, 8'h0, 8'h38, 88'h0}, 1'b0, 0, "reload");
    idle_check("reload");

    for (int r = 0; r < 6; r++) begin
      run_frame(rand_frame(1'b1), 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
